// File: rtl/stud_ds_decimator_pkg.sv
// ----------------------------------------------------------------------------
// stud_ds_decimator_pkg
// Shared definitions for the delta-sigma receive decimator:
//   - CIC order and the derived internal accumulator width
//   - warm-up state encoding used by the top-level FSM
// Build option: STUD_DS_DECIM_UNSIGNED_EN (consumed in stud_ds_decimator.sv)
// selects offset-binary output instead of two's-complement.
// ----------------------------------------------------------------------------
package stud_ds_decimator_pkg;

    // Second-order CIC: two integrators, two comb stages.
    localparam int CIC_ORDER = 2;

    // Internal width: CIC bit growth is ORDER*log2(R), plus a sign bit and one
    // spare so the steady-state extreme +/-R**2 stays representable.
    function automatic int cic_width(input int osr_log2);
        return (CIC_ORDER * osr_log2) + 2;
    endfunction

    // The comb delay line needs one decimation point per stage to fill
    // before its output is meaningful.
    typedef enum logic [1:0] {
        ST_WARM0 = 2'd0,
        ST_WARM1 = 2'd1,
        ST_RUN   = 2'd2
    } warm_e;

endpackage

// File: rtl/stud_ds_decimator_integrator.sv
// ----------------------------------------------------------------------------
// stud_ds_decimator_integrator
// W-bit wrapping accumulator (one CIC integrator stage).
// Ports:
//   clk_i    clock
//   n_rst_i  asynchronous active-low reset, clears the accumulator
//   i_en     accumulate this cycle
//   i_inc    two's-complement increment
//   o_acc    current (registered) accumulator value
// ----------------------------------------------------------------------------
module stud_ds_decimator_integrator #(
    parameter int W = 12
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         i_en,
    input  logic [W-1:0] i_inc,
    output logic [W-1:0] o_acc
);

    logic [W-1:0] r_acc;

    // Accumulator: modulo-2**W wrap is intentional, CIC arithmetic relies on it.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_acc <= {W{1'b0}};
        end else if (i_en) begin
            r_acc <= r_acc + i_inc;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/stud_ds_decimator.sv
// ----------------------------------------------------------------------------
// stud_ds_decimator
// Decodes a 1-bit delta-sigma bitstream into PCM using a second-order CIC
// decimator (R = 2**OSR_LOG2), then scales and saturates to AUDIO_WIDTH.
// Ports:
//   clk_i          clock
//   n_rst_i        asynchronous active-low reset
//   en_i           bitstream sample enable
//   ds_i           bitstream bit (1 => +1, 0 => -1)
//   audio_o        PCM sample, held between strobes
//   audio_valid_o  one-cycle strobe, new audio_o valid
// Build option: define STUD_DS_DECIM_UNSIGNED_EN for offset-binary output
// (silence and reset value = MSB set); default is two's-complement.
// ----------------------------------------------------------------------------
module stud_ds_decimator
    import stud_ds_decimator_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16,
    parameter int OSR_LOG2    = 5
) (
    input  logic                   clk_i,
    input  logic                   n_rst_i,
    input  logic                   en_i,
    input  logic                   ds_i,
    output logic [AUDIO_WIDTH-1:0] audio_o,
    output logic                   audio_valid_o
);

    localparam int W     = cic_width(OSR_LOG2);
    localparam int SHIFT = AUDIO_WIDTH - 1 - (CIC_ORDER * OSR_LOG2);
    // W + SHIFT == AUDIO_WIDTH + 1: one guard bit above the output range.
    localparam int XW    = W + SHIFT;

    localparam logic [OSR_LOG2-1:0]    CNT_LAST = {OSR_LOG2{1'b1}};
    localparam logic [OSR_LOG2-1:0]    CNT_ONE  = {{(OSR_LOG2-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0]   SAT_MAX  = {2'b00, {(AUDIO_WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0]   SAT_MIN  = {2'b11, {(AUDIO_WIDTH-1){1'b0}}};
    localparam logic [AUDIO_WIDTH-1:0] MSB_ONE  = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};

    logic [W-1:0]           w_step;
    logic [W-1:0]           w_int1;
    logic [W-1:0]           w_int2;
    logic [W-1:0]           w_int2_next;
    logic [W-1:0]           w_c1;
    logic [W-1:0]           w_c2;
    logic signed [XW-1:0]   w_c2_ext;
    logic signed [XW-1:0]   w_scaled;
    logic [AUDIO_WIDTH-1:0] w_sat;
    logic [AUDIO_WIDTH-1:0] w_audio_fmt;
    logic                   w_dec_point;

    logic [OSR_LOG2-1:0]    r_dec_cnt;
    warm_e                  r_warm;
    logic [W-1:0]           r_d1;
    logic [W-1:0]           r_d2;
    logic [AUDIO_WIDTH-1:0] r_audio;
    logic                   r_valid;

    // +1 is 0..01, -1 is all ones: only the upper bits depend on ds_i.
    assign w_step = {{(W-1){~ds_i}}, 1'b1};

    stud_ds_decimator_integrator #(.W(W)) u_int1 (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .i_en    (en_i),
        .i_inc   (w_step),
        .o_acc   (w_int1)
    );

    // Second integrator adds the pre-update value of the first.
    stud_ds_decimator_integrator #(.W(W)) u_int2 (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .i_en    (en_i),
        .i_inc   (w_int1),
        .o_acc   (w_int2)
    );

    // The comb works on the value int2 takes at this edge, so no extra latency.
    assign w_int2_next = w_int2 + w_int1;
    assign w_dec_point = en_i & (r_dec_cnt == CNT_LAST);
    assign w_c1        = w_int2_next - r_d1;
    assign w_c2        = w_c1 - r_d2;

    // Sign-extend the comb output to the scaling width.
    always_comb begin
        w_c2_ext         = {XW{w_c2[W-1]}};
        w_c2_ext[W-1:0]  = w_c2;
    end

    assign w_scaled = w_c2_ext <<< SHIFT;

    // Clamp to the output range; only +R**2 can actually exceed it.
    always_comb begin
        w_sat = w_scaled[AUDIO_WIDTH-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[AUDIO_WIDTH-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[AUDIO_WIDTH-1:0];
        end else begin
            w_sat = w_scaled[AUDIO_WIDTH-1:0];
        end
    end

`ifdef STUD_DS_DECIM_UNSIGNED_EN
    // Adding 2**(AUDIO_WIDTH-1) modulo 2**AUDIO_WIDTH is an MSB flip.
    localparam logic [AUDIO_WIDTH-1:0] AUDIO_RST = MSB_ONE;
    assign w_audio_fmt = w_sat ^ MSB_ONE;
`else
    localparam logic [AUDIO_WIDTH-1:0] AUDIO_RST = {AUDIO_WIDTH{1'b0}};
    assign w_audio_fmt = w_sat;
`endif

    // Decimation counter, comb delays, warm-up FSM and registered outputs.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_dec_cnt <= {OSR_LOG2{1'b0}};
            r_warm    <= ST_WARM0;
            r_d1      <= {W{1'b0}};
            r_d2      <= {W{1'b0}};
            r_audio   <= AUDIO_RST;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (en_i) begin
                r_dec_cnt <= r_dec_cnt + CNT_ONE;
            end else begin
                r_dec_cnt <= r_dec_cnt;
            end
            if (w_dec_point) begin
                r_d1 <= w_int2_next;
                r_d2 <= w_c1;
                case (r_warm)
                    ST_WARM0: r_warm <= ST_WARM1;
                    ST_WARM1: r_warm <= ST_RUN;
                    ST_RUN: begin
                        r_audio <= w_audio_fmt;
                        r_valid <= 1'b1;
                    end
                    default:  r_warm <= ST_WARM0;
                endcase
            end else begin
                r_d1 <= r_d1;
                r_d2 <= r_d2;
            end
        end
    end

    assign audio_o       = r_audio;
    assign audio_valid_o = r_valid;

endmodule

// File: tb/tb_stud_ds_decimator.sv
module tb_stud_ds_decimator;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic        ds;
    logic [15:0] audio;
    logic        valid;

    int n_cmp;
    int n_bad;
    int en_cnt;
    int strobes;

`ifdef STUD_DS_DECIM_UNSIGNED_EN
    localparam logic [15:0] FMT_XOR = 16'h8000;
`else
    localparam logic [15:0] FMT_XOR = 16'h0000;
`endif

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp_signed;
    } vec_t;

    vec_t vecs[4];

    stud_ds_decimator #(.AUDIO_WIDTH(16), .OSR_LOG2(5)) dut (
        .clk_i         (clk),
        .n_rst_i       (n_rst),
        .en_i          (en),
        .ds_i          (ds),
        .audio_o       (audio),
        .audio_valid_o (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic tick(input logic e, input logic d);
        en = e;
        ds = d;
        @(posedge clk);
        #1;
        if (e) en_cnt++;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        en    = 1'b0;
        ds    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_audio", {16'd0, audio}, {16'd0, FMT_XOR});
        @(negedge clk);
        n_rst  = 1'b1;
        en_cnt = 0;
    endtask

    function automatic logic pat_bit(input int kind, input int idx);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (idx % 2) == 0;
            3:       return (idx % 4) != 3;
            default: return 1'b0;
        endcase
    endfunction

    // Strobe expected after the enabled cycle that is the 3rd, 4th, ... decimation point.
    function automatic logic exp_strobe(input logic e, input int cnt);
        return e && (cnt >= 96) && ((cnt % 32) == 0);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        strobes = 0;
        en_cnt = 0;
        n_rst = 1'b0;
        en = 1'b0;
        ds = 1'b0;

        vecs[0] = '{name: "all_ones",   kind: 0, exp_signed: 16'h7FFF};
        vecs[1] = '{name: "all_zeros",  kind: 1, exp_signed: 16'h8000};
        vecs[2] = '{name: "toggle",     kind: 2, exp_signed: 16'h0000};
        vecs[3] = '{name: "three_of4",  kind: 3, exp_signed: 16'h4000};

        // Table-driven steady-state patterns with continuous enable.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            strobes = 0;
            for (int i = 0; i < 96 + 32 * 3; i++) begin
                tick(1'b1, pat_bit(vecs[v].kind, i));
                check({vecs[v].name, "_valid"}, {31'd0, valid},
                      {31'd0, exp_strobe(1'b1, en_cnt)});
                if (en_cnt >= 96)
                    check({vecs[v].name, "_audio"}, {16'd0, audio},
                          {16'd0, vecs[v].exp_signed ^ FMT_XOR});
                if (valid) strobes++;
            end
            check({vecs[v].name, "_strobes"}, strobes, 4);
        end

        // Random enable gaps, ds_i = 1: strobes only after enabled decimation points.
        do_reset();
        strobes = 0;
        for (int i = 0; i < 600; i++) begin
            logic e;
            e = 1'($urandom_range(0, 1));
            tick(e, 1'b1);
            check("rand_valid", {31'd0, valid}, {31'd0, exp_strobe(e, en_cnt)});
            if (valid) begin
                strobes++;
                check("rand_audio", {16'd0, audio}, {16'd0, 16'h7FFF ^ FMT_XOR});
            end
        end
        check("rand_strobes_min", {31'd0, strobes >= 4}, 32'd1);

        // Hand sequence: enable dropped right after a decimation point and
        // held low, then resumed; strobe must not repeat or be lost.
        do_reset();
        for (int i = 0; i < 96; i++) tick(1'b1, 1'b1);
        check("gap_first_strobe", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1);
            check("gap_idle_valid", {31'd0, valid}, 32'd0);
        end
        for (int i = 0; i < 31; i++) begin
            tick(1'b1, 1'b1);
            check("gap_mid_valid", {31'd0, valid}, 32'd0);
        end
        tick(1'b1, 1'b1);
        check("gap_next_strobe", {31'd0, valid}, 32'd1);

        // Asynchronous reset between edges while a strobe is being presented.
        do_reset();
        for (int i = 0; i < 96; i++) tick(1'b1, 1'b1);
        check("pre_areset_valid", {31'd0, valid}, 32'd1);
        check("pre_areset_audio", {16'd0, audio}, {16'd0, 16'h7FFF ^ FMT_XOR});
        #3;
        n_rst = 1'b0;
        #1;
        check("areset_valid", {31'd0, valid}, 32'd0);
        check("areset_audio", {16'd0, audio}, {16'd0, FMT_XOR});
        @(negedge clk);
        n_rst  = 1'b1;
        en_cnt = 0;
        strobes = 0;
        for (int i = 0; i < 96; i++) begin
            tick(1'b1, 1'b1);
            check("rewarm_valid", {31'd0, valid}, {31'd0, exp_strobe(1'b1, en_cnt)});
            if (valid) strobes++;
        end
        check("rewarm_strobes", strobes, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
